me_iddmm_arb: RTL and testbench

- Two-channel round-robin scheduler that shares one me_iddmm_top modular-exponentiation engine between two requesters.
- For each granted requester it issues me_start, waits a fixed gap, then streams N operand word pairs plus one zero pad word into the engine.
- It captures the N-word result burst and returns it tagged with the owner channel id.
- Sits between the Paillier/RSA front-end request queues and the single engine instance.

---
 rtl/me_iddmm_arb.sv | 153 +++++++++++++++
 tb/tb_me_iddmm_arb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_iddmm_arb.sv
// me_iddmm_arb: round-robin scheduler sharing one me_iddmm_top engine between two requesters (optional WAIT watchdog: ME_ARB_TIMEOUT_EN)
module me_iddmm_arb #(
    parameter int K         = 128,
    parameter int N         = 32,
    parameter int START_GAP = 10,
    parameter int TIMEOUT   = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    output logic         gnt0,
    output logic         gnt1,
    input  logic [K-1:0] x0,
    input  logic [K-1:0] y0,
    input  logic [K-1:0] x1,
    input  logic [K-1:0] y1,
    input  logic         v0,
    input  logic         v1,
    output logic         me_start,
    output logic [K-1:0] me_x,
    output logic [K-1:0] me_y,
    output logic         me_x_valid,
    output logic         me_y_valid,
    input  logic [K-1:0] me_result,
    input  logic         me_valid,
    output logic [K-1:0] res_data,
    output logic         res_valid,
    output logic         res_id,
    output logic         busy,
    output logic         err
);
    localparam int WW = $clog2(N + 1);
    localparam int GW = $clog2(START_GAP + 1);

    if (N < 2 || START_GAP < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("me_iddmm_arb: N and START_GAP must be >= 2, TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, GAP, LOAD, PAD, WAIT, COLLECT} state_t;

    state_t        state, state_nx;
    logic          owner, owner_nx, last_owner, last_owner_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic [K-1:0]  ox, oy;
    logic          ov, tout, cap;

    assign ox = owner ? x1 : x0;
    assign oy = owner ? y1 : y0;
    assign ov = owner ? v1 : v0;

`ifdef ME_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    // watchdog: counts cycles spent in WAIT, cleared everywhere else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tcnt <= '0;
        else        tcnt <= (state == WAIT) ? tcnt + TW'(1) : '0;
    assign tout = (state == WAIT) && !me_valid && (tcnt == TW'(TIMEOUT));
`else
    assign tout = 1'b0;
`endif

    assign err        = tout;
    assign busy       = (state != IDLE);
    assign me_start   = (state == START);
    assign gnt0       = (state == LOAD) && !owner;
    assign gnt1       = (state == LOAD) && owner;
    assign me_y_valid = me_x_valid;
    assign cap        = ((state == WAIT) && me_valid) || (state == COLLECT);

    // state, ownership and counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wcnt       <= '0;
            gcnt       <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            wcnt       <= wcnt_nx;
            gcnt       <= gcnt_nx;
        end

    // next state; GAP lasts START_GAP-1 cycles because the first LOAD cycle
    // still presents zeros to the engine through the output register
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        wcnt_nx       = wcnt;
        gcnt_nx       = gcnt;
        unique case (state)
            IDLE: if (req0 || req1) begin
                owner_nx = (req0 && req1) ? !last_owner : req1;
                state_nx = START;
            end
            START: begin
                gcnt_nx  = '0;
                state_nx = GAP;
            end
            GAP: begin
                gcnt_nx  = gcnt + GW'(1);
                state_nx = (gcnt == GW'(START_GAP - 2)) ? LOAD : GAP;
            end
            LOAD: if (ov) begin
                wcnt_nx  = wcnt + WW'(1);
                state_nx = (wcnt == WW'(N - 1)) ? PAD : LOAD;
            end
            PAD: begin
                wcnt_nx  = '0;
                state_nx = WAIT;
            end
            WAIT: if (tout) begin
                last_owner_nx = owner;
                state_nx      = IDLE;
            end else if (me_valid) begin
                wcnt_nx  = WW'(1);
                state_nx = COLLECT;
            end
            COLLECT: if (wcnt == WW'(N - 1)) begin
                wcnt_nx       = '0;
                last_owner_nx = owner;
                state_nx      = IDLE;
            end else begin
                wcnt_nx = wcnt + WW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    // registered engine operands and result words
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            me_x       <= '0;
            me_y       <= '0;
            me_x_valid <= 1'b0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            me_x       <= (state == LOAD) ? ox : '0;
            me_y       <= (state == LOAD) ? oy : '0;
            me_x_valid <= (state == LOAD) ? ov : (state == PAD);
            res_data   <= cap ? me_result : '0;
            res_valid  <= cap;
            res_id     <= cap && owner;
        end
endmodule

// File: tb/tb_me_iddmm_arb.sv
// tb_me_iddmm_arb: directed bench with requester/engine models and a per-cycle scoreboard
`timescale 1ns/1ps
module tb_me_iddmm_arb;
    localparam int K = 128, N = 32, SG = 10, TO = 100;

    typedef struct packed { logic [K-1:0] x; logic [K-1:0] y; } pair_t;
    typedef struct { logic id; logic [K-1:0] d; } res_t;

    logic clk = 0, rst_n = 0;
    logic [1:0] req = '0, v = '0;
    logic [K-1:0] x[2], y[2];
    logic gnt0, gnt1, me_start, me_x_valid, me_y_valid, me_valid, res_valid, res_id, busy, err;
    logic [K-1:0] me_x, me_y, me_result, res_data;

    me_iddmm_arb #(.K(K), .N(N), .START_GAP(SG), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req[0]), .req1(req[1]), .gnt0(gnt0), .gnt1(gnt1),
        .x0(x[0]), .y0(y[0]), .x1(x[1]), .y1(y[1]), .v0(v[0]), .v1(v[1]),
        .me_start(me_start), .me_x(me_x), .me_y(me_y), .me_x_valid(me_x_valid), .me_y_valid(me_y_valid),
        .me_result(me_result), .me_valid(me_valid), .res_data(res_data), .res_valid(res_valid),
        .res_id(res_id), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int pend[2], widx[2], jobno[2], bub_at[2], bub_len[2], bub_cnt[2];
    bit in_job[2];
    bit silent = 0;
    pair_t fwd_q[$];
    res_t res_q[$];
    int gq[$], vt[$];
    int nvalid, nres, n_err, start_cyc, pad_cyc;
    bit lat_pend, prev_start, prev_err, got_first;
    logic [K-1:0] first_res, last_res;

    function automatic logic [K-1:0] word_x(input int c, input int j, input int i);
        return K'(i + 1) + (K'(c) << 8) + (K'(j) << 12) + (K'(c + j) << 96);
    endfunction

    function automatic logic [K-1:0] word_y(input logic [K-1:0] wx);
        return (wx << 4) ^ K'(5);
    endfunction

    task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic requester(input int c);
        logic g;
        logic [K-1:0] wx;
        forever begin
            @(posedge clk); #1;
            g = c[0] ? gnt1 : gnt0;
            if (!rst_n) begin
                req[c] = 0; v[c] = 0; in_job[c] = 0; widx[c] = 0; bub_cnt[c] = 0;
            end else if (g) begin
                req[c] = 0;
                if (!in_job[c]) begin
                    in_job[c] = 1;
                    gq.push_back(c);
                    if (!silent)
                        for (int i = 0; i < N; i++) begin
                            wx = word_x(c, jobno[c], i);
                            res_q.push_back('{id: c[0], d: wx * 3 + word_y(wx)});
                        end
                end
                v[c] = 0;
                if (widx[c] < N) begin
                    if (widx[c] == bub_at[c] && bub_cnt[c] < bub_len[c]) begin
                        bub_cnt[c]++;
                        x[c] = '0; y[c] = '0;
                    end else begin
                        wx = word_x(c, jobno[c], widx[c]);
                        x[c] = wx; y[c] = word_y(wx); v[c] = 1;
                        fwd_q.push_back('{x: wx, y: word_y(wx)});
                        widx[c]++;
                        if (widx[c] == N) fwd_q.push_back('{x: '0, y: '0});
                    end
                end
            end else begin
                v[c] = 0;
                if (in_job[c]) begin
                    in_job[c] = 0; widx[c] = 0; bub_cnt[c] = 0; jobno[c]++; pend[c]--;
                end
                req[c] = pend[c] > 0;
            end
        end
    endtask

    initial requester(0);
    initial requester(1);

    // engine model: takes N+1 words, answers with N words x*3+y a few cycles later
    logic [K-1:0] ex[N+1], ey[N+1];
    int ecnt = 0;
    initial begin
        me_valid = 0; me_result = '1;
        forever begin
            @(posedge clk); #1;
            me_valid = 0; me_result = '1;
            if (!rst_n) ecnt = 0;
            else if (me_x_valid && ecnt <= N) begin
                ex[ecnt] = me_x; ey[ecnt] = me_y; ecnt++;
                if (ecnt == N + 1) begin
                    ecnt = 0;
                    if (!silent) begin
                        repeat (3) @(posedge clk);
                        for (int i = 0; i < N; i++) begin
                            @(posedge clk); #1;
                            if (!rst_n) begin me_valid = 0; break; end
                            me_valid = 1; me_result = ex[i] * 3 + ey[i];
                        end
                    end
                end
            end
        end
    end

    // scoreboard: checks every cycle out of reset
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            lat_pend = 0; prev_start = 0; prev_err = 0;
        end else begin
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            chk("valid_equal", me_x_valid, me_y_valid);
            chk("start_one_cycle", me_start & prev_start, 0);
            if (gnt0 | gnt1 | me_start) chk("busy_active", busy, 1);
            if (me_start) begin start_cyc = cyc; lat_pend = 1; end
            if (me_x_valid) begin
                nvalid++;
                vt.push_back(cyc);
                if (lat_pend) begin chk("start_to_word_lat", cyc - start_cyc, 11); lat_pend = 0; end
                if (fwd_q.size() == 0) chk("fwd_extra_word", 1, 0);
                else begin
                    pair_t p;
                    p = fwd_q.pop_front();
                    chk("me_x", me_x, p.x);
                    chk("me_y", me_y, p.y);
                    if (p.x == '0 && p.y == '0) pad_cyc = cyc;
                end
            end
            if (res_valid) begin
                nres++;
                if (!got_first) begin first_res = res_data; got_first = 1; end
                last_res = res_data;
                if (res_q.size() == 0) chk("res_extra_word", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res_data", res_data, r.d);
                    chk("res_id", res_id, r.id);
                end
            end
`ifdef ME_ARB_TIMEOUT_EN
            if (err) begin n_err++; chk("err_timing", cyc - pad_cyc, TO); end
            if (prev_err) chk("busy_after_err", busy, 0);
`else
            chk("err_tied_low", err, 0);
`endif
            prev_start = me_start;
            prev_err = err;
        end
    end

    task automatic clear_stats();
        nvalid = 0; nres = 0; n_err = 0; got_first = 0;
        vt.delete(); gq.delete();
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (pend[0] == 0 && pend[1] == 0 && !busy && res_q.size() == 0) break;
        end
        if (i == budget) chk("wait_done_budget", 1, 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_order(input string nm, input int n, input int e0, input int e1, input int e2);
        int e[3];
        e = '{e0, e1, e2};
        chk({nm, "_count"}, gq.size(), n);
        for (int i = 0; i < n; i++) chk(nm, (i < gq.size()) ? gq[i] : 7, e[i]);
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        fwd_q.delete(); res_q.delete();
        rst_n = 1;
        @(posedge clk); #2;
    endtask

    initial begin
        int i;
        x = '{'0, '0}; y = '{'0, '0};
        pend = '{0, 0}; widx = '{0, 0}; jobno = '{0, 0};
        bub_at = '{-1, -1}; bub_len = '{0, 0}; bub_cnt = '{0, 0};
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_me_start", me_start, 0);
        chk("rst_me_valid", me_x_valid, 0);
        chk("rst_me_x", me_x, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err, 0);
        rst_n = 1;
        @(posedge clk); #2;
        chk("post_rst_busy", busy, 0);

        // single request on ch0
        clear_stats();
        pend[0] = 1;
        wait_done(3000);
        chk("t1_valid_words", nvalid, N + 1);
        chk("t1_res_words", nres, N);
        chk("t1_first_res", first_res, 128'h18);
        chk("t1_last_res", last_res, 128'h265);
        check_order("t1_order", 1, 0, 0, 0);

        // simultaneous requests after reset: ch0 first
        pulse_reset();
        clear_stats();
        pend = '{1, 1};
        wait_done(6000);
        chk("t2_res_words", nres, 2 * N);
        check_order("t2_order", 2, 0, 1, 0);

        // ch0 kept busy, ch1 arrives mid-job and must be served next
        clear_stats();
        pend[0] = 2;
        for (i = 0; i < 500 && !gnt0; i++) begin @(posedge clk); #2; end
        chk("t3_gnt0_seen", gnt0, 1);
        repeat (5) @(posedge clk);
        #2;
        pend[1] = 1;
        wait_done(9000);
        chk("t3_res_words", nres, 3 * N);
        check_order("t3_order", 3, 0, 1, 0);

        // three-cycle bubble before word 5
        clear_stats();
        bub_at[0] = 5; bub_len[0] = 3;
        pend[0] = 1;
        wait_done(3000);
        bub_len[0] = 0;
        chk("t4_valid_words", nvalid, N + 1);
        chk("t4_span", (vt.size() == N + 1) ? vt[N] - vt[0] + 1 : 0, N + 4);
        chk("t4_gap_at_5", (vt.size() > 5) ? vt[5] - vt[4] : 0, 4);

        // asynchronous reset in the middle of LOAD
        clear_stats();
        pend[0] = 1;
        for (i = 0; i < 500 && widx[0] != 12; i++) begin @(posedge clk); #2; end
        chk("t5_reached_word12", widx[0], 12);
        #1 rst_n = 0;
        #1;
        chk("t5_busy_async", busy, 0);
        chk("t5_gnt_async", {gnt1, gnt0}, 0);
        chk("t5_me_valid_async", me_x_valid, 0);
        chk("t5_me_x_async", me_x, 0);
        pend[0] = 0;
        repeat (2) @(posedge clk);
        #2;
        fwd_q.delete(); res_q.delete();
        rst_n = 1;
        @(posedge clk); #2;
        chk("t5_busy_after", busy, 0);
        clear_stats();
        pend[0] = 1;
        wait_done(3000);
        chk("t5_valid_words", nvalid, N + 1);
        chk("t5_res_words", nres, N);

`ifdef ME_ARB_TIMEOUT_EN
        // silent engine trips the watchdog
        clear_stats();
        silent = 1;
        pend[0] = 1;
        wait_done(3000);
        silent = 0;
        chk("t6_err_pulses", n_err, 1);
        chk("t6_res_words", nres, 0);
        chk("t6_valid_words", nvalid, N + 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1, "bench timeout");
    end
endmodule
